// File: rtl/meas_chan_mux.sv
// Registered N-channel measurement multiplexer: manual or round-robin channel pick,
// programmable settle delay, sample delivered over a valid/ready handshake.
module meas_chan_mux #(
  parameter  int WIDTH  = 32,
  parameter  int NCH    = 4,
  parameter  int SETTLE = 2,
  localparam int CW     = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] data_in,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 auto_mode,
  input  logic [CW-1:0]        man_sel,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 out_valid,
  output logic                 scan_done
);
  localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_PRESENT} state_t;

  state_t          r_state, w_nxt_state;
  logic [CNTW-1:0] r_cnt, w_nxt_cnt;
  logic [CW-1:0]   r_sel, w_nxt_sel, r_ptr, w_nxt_ptr;
  logic            r_man, w_nxt_man, w_nxt_valid, w_nxt_done, w_load;
  logic [CW-1:0]   w_base, w_idx_hi, w_idx_lo, w_man_ch, w_pick;
  logic            w_hi, w_lo, w_pick_ok;

  // Next-channel search: lowest enabled index above the base, else lowest enabled overall.
  // At a handshake the base is the channel just accepted, so !w_hi also marks end of scan.
  always_comb begin
    w_base   = (r_state == ST_PRESENT) ? out_ch : r_ptr;
    w_hi     = 1'b0;
    w_lo     = 1'b0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    for (int j = NCH-1; j >= 0; j--) begin
      if (ch_en[j]) begin
        w_lo     = 1'b1;
        w_idx_lo = CW'(j);
        if (j > int'(w_base)) begin
          w_hi     = 1'b1;
          w_idx_hi = CW'(j);
        end
      end
    end
    w_man_ch  = (int'(man_sel) >= NCH) ? '0 : man_sel;
    w_pick_ok = !auto_mode || w_lo;
    w_pick    = !auto_mode ? w_man_ch : (w_hi ? w_idx_hi : w_idx_lo);
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_sel   = r_sel;
    w_nxt_man   = r_man;
    w_nxt_ptr   = r_ptr;
    w_nxt_valid = out_valid;
    w_nxt_done  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_ok) begin
          w_nxt_sel   = w_pick;
          w_nxt_man   = !auto_mode;
          w_nxt_cnt   = '0;
          w_nxt_state = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Only a manually chosen channel follows man_sel while settling.
        if (r_man && !auto_mode && (w_man_ch != r_sel)) begin
          w_nxt_sel = w_man_ch;
          w_nxt_cnt = '0;
        end else if (int'(r_cnt) == SETTLE-1) begin
          w_load      = 1'b1;
          w_nxt_valid = 1'b1;
          w_nxt_state = ST_PRESENT;
        end else begin
          w_nxt_cnt = CNTW'(r_cnt + 1'b1);
        end
      end
      ST_PRESENT: begin
        if (out_valid && out_ready) begin
          w_nxt_valid = 1'b0;
          w_nxt_ptr   = out_ch;
          w_nxt_done  = auto_mode && !w_hi;
          if (w_pick_ok) begin
            w_nxt_sel   = w_pick;
            w_nxt_man   = !auto_mode;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_SETTLE;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_man     <= 1'b0;
      r_ptr     <= CW'(NCH-1);
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_sel     <= w_nxt_sel;
      r_man     <= w_nxt_man;
      r_ptr     <= w_nxt_ptr;
      out_valid <= w_nxt_valid;
      scan_done <= w_nxt_done;
      if (w_load) begin
        out_data <= data_in[r_sel*WIDTH +: WIDTH];
        out_ch   <= r_sel;
      end
    end
  end
endmodule
